// File: rtl/count_load_sequencer.sv
// Command sequencer for a loadable up counter: queues {start, stop} pairs,
// loads each start value into the counter and signals done once it reaches stop.
module count_load_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_start,
    input  logic [3:0] cmd_stop,
    input  logic       abort,
    input  logic [3:0] cnt_in,
    output logic       ld,
    output logic [3:0] ldvalue,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t           state_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [3:0]       stop_q;
    logic             ld_q;
    logic [3:0]       ldvalue_q;
    logic             busy_q;
    logic             done_q;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       match;
    logic [3:0] head_start;
    logic [3:0] head_stop;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign match     = (cnt_in == stop_q);

    assign {head_start, head_stop} = mem_q[rd_ptr_q];

    // The head is consumed when a command starts from IDLE, or when the active
    // command completes and the next one chains straight into LOAD.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        pop     = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE:    pop = !empty;
            RUN:     pop = match && !abort && !empty;
            default: pop = 1'b0;
        endcase
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: storage array is not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_start, cmd_stop};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            stop_q    <= '0;
            ld_q      <= 1'b0;
            ldvalue_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            ld_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        stop_q    <= head_stop;
                        ld_q      <= 1'b1;
                        ldvalue_q <= head_start;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over a coincident match: no done for a cancelled command.
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (match) begin
                        done_q <= 1'b1;
                        if (!empty) begin
                            stop_q    <= head_stop;
                            ld_q      <= 1'b1;
                            ldvalue_q <= head_start;
                            state_q   <= LOAD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ld      = ld_q;
    assign ldvalue = ldvalue_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_count_load_sequencer.sv
// Bench for count_load_sequencer: drives a modelled up counter and compares every
// cycle against a timing-based reference of the command queue.
module tb_count_load_sequencer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0] start;
        logic [3:0] stop;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start;
    logic [3:0] cmd_stop;
    logic       abort;
    logic [3:0] cnt_in;
    logic       ld;
    logic [3:0] ldvalue;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Reference: pending queue plus a countdown of edges until the active command ends.
    cmd_t       mq[$];
    bit         m_act;
    int         m_left;
    bit         m_ld;
    bit         m_done;
    logic [3:0] m_ldv;

    int         cyc;
    int         done_cnt;
    int         ld_cyc;
    int         fall_cyc;
    int         done_cyc;
    int         acc_cyc;
    bit         prev_ld;
    bit         last_acc;
    logic       ld_at_done;
    logic [3:0] ldv_at_done;
    logic [3:0] ld_log[$];

    count_load_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_stop  (cmd_stop),
        .abort     (abort),
        .cnt_in    (cnt_in),
        .ld        (ld),
        .ldvalue   (ldvalue),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Downstream up counter: loads on ld, otherwise counts with natural 4-bit wrap.
    always @(posedge clk) begin
        cnt_in <= (ld === 1'b1) ? ldvalue : cnt_in + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check outputs, then advance the model.
    task automatic step(input bit v, input logic [3:0] s, input logic [3:0] p,
                        input bit a, input bit r);
        bit   exp_ready;
        bit   was_idle;
        bit   finished;
        cmd_t c;
        cmd_valid = v;
        cmd_start = s;
        cmd_stop  = p;
        abort     = a;
        rst       = r;
        #1;
        cyc++;
        exp_ready = !r && (mq.size() < DEPTH);
        check("cmd_ready", cmd_ready, exp_ready);
        check("ld", ld, m_ld);
        check("ldvalue", ldvalue, m_ldv);
        check("busy", busy, m_act);
        check("done", done, m_done);
        if (ld === 1'b1) begin
            ld_cyc = cyc;
            ld_log.push_back(ldvalue);
        end
        if (prev_ld && ld === 1'b0) fall_cyc = cyc;
        prev_ld = (ld === 1'b1);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc    = cyc;
            ld_at_done  = ld;
            ldv_at_done = ldvalue;
        end
        last_acc = v && exp_ready;
        if (last_acc) acc_cyc = cyc;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_act  = 1'b0;
            m_ld   = 1'b0;
            m_ldv  = 4'd0;
            m_done = 1'b0;
        end else begin
            was_idle = !m_act;
            finished = 1'b0;
            m_ld     = 1'b0;
            m_done   = 1'b0;
            if (m_act) begin
                if (a) begin
                    m_act = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done   = 1'b1;
                        m_act    = 1'b0;
                        finished = 1'b1;
                    end
                end
            end
            if ((was_idle || finished) && mq.size() > 0) begin
                c      = mq.pop_front();
                m_ld   = 1'b1;
                m_ldv  = c.start;
                m_act  = 1'b1;
                // One edge to leave LOAD, then ((stop-start) mod 16)+1 compares.
                m_left = (16 + int'(c.stop) - int'(c.start)) % 16 + 2;
            end
            if (last_acc) begin
                c.start = s;
                c.stop  = p;
                mq.push_back(c);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic run_until_done(input int max);
        int start_cnt;
        int i;
        start_cnt = done_cnt;
        i = 0;
        while (done_cnt == start_cnt && i < max) begin
            idle(1);
            i++;
        end
        check("done_timeout", done_cnt != start_cnt, 1);
    endtask

    initial begin
        int         n;
        int         d0;
        int         l0;
        logic [3:0] exp_order[6];
        cyc      = 0;
        done_cnt = 0;
        prev_ld  = 1'b0;
        m_act    = 1'b0;
        m_ld     = 1'b0;
        m_done   = 1'b0;
        m_ldv    = 4'd0;
        m_left   = 0;
        cmd_valid = 1'b0;
        cmd_start = 4'd0;
        cmd_stop  = 4'd0;
        abort     = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset, with a command offered while reset is held.
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 4'd9, 4'd9, 1'b0, 1'b1);
        idle(3);
        check("rst_drop_busy", busy, 0);
        check("rst_drop_ld_count", ld_log.size(), 0);

        // Single command (3,7).
        step(1'b1, 4'd3, 4'd7, 1'b0, 1'b0);
        run_until_done(30);
        check("single_ld_latency", ld_cyc - acc_cyc, 2);
        check("single_ldvalue", ld_log[$], 3);
        check("single_done_dist", done_cyc - fall_cyc, 5);
        idle(1);
        check("single_busy_after", busy, 0);

        // Wrap (14,1).
        step(1'b1, 4'd14, 4'd1, 1'b0, 1'b0);
        run_until_done(30);
        check("wrap_done_dist", done_cyc - fall_cyc, 4);
        idle(2);

        // Back-to-back (5,5) then (9,10).
        step(1'b1, 4'd5, 4'd5, 1'b0, 1'b0);
        step(1'b1, 4'd9, 4'd10, 1'b0, 1'b0);
        run_until_done(20);
        check("b2b_first_dist", done_cyc - fall_cyc, 1);
        check("b2b_ld_with_done", ld_at_done, 1);
        check("b2b_ldvalue_with_done", ldv_at_done, 9);
        run_until_done(20);
        check("b2b_second_dist", done_cyc - fall_cyc, 2);
        idle(2);

        // FIFO full: long first command, then four queued and a fifth held.
        ld_log.delete();
        d0 = done_cnt;
        step(1'b1, 4'd0, 4'd15, 1'b0, 1'b0);
        idle(2);
        step(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd4, 4'd4, 1'b0, 1'b0);
        step(1'b1, 4'd6, 4'd7, 1'b0, 1'b0);
        check("full_ready_low", cmd_ready, 0);
        n = 0;
        do begin
            step(1'b1, 4'd8, 4'd9, 1'b0, 1'b0);
            n++;
        end while (!last_acc && n < 40);
        check("full_fifth_accepted", last_acc, 1);
        check("full_fifth_was_held", n > 1, 1);
        n = 0;
        while (done_cnt - d0 < 5 && n < 200) begin
            idle(1);
            n++;
        end
        check("full_all_done", done_cnt - d0, 5);
        exp_order = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8};
        check("full_ld_count", ld_log.size(), 6);
        for (int i = 0; i < 6 && i < ld_log.size(); i++) begin
            check("full_ld_order", ld_log[i], exp_order[i]);
        end
        idle(2);

        // Abort (0,12) at count 4 with (2,3) queued.
        step(1'b1, 4'd0, 4'd12, 1'b0, 1'b0);
        step(1'b1, 4'd2, 4'd3, 1'b0, 1'b0);
        n = 0;
        while (!(busy === 1'b1 && ld === 1'b0 && cnt_in === 4'd4) && n < 30) begin
            idle(1);
            n++;
        end
        check("abort_reach_count", cnt_in, 4);
        d0 = done_cnt;
        l0 = ld_log.size();
        step(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
        check("abort_busy_drop", busy, 0);
        check("abort_no_done", done, 0);
        n = 0;
        while (ld_log.size() == l0 && n < 10) begin
            idle(1);
            n++;
        end
        check("abort_next_loaded", ld_log.size() > l0, 1);
        if (ld_log.size() > l0) check("abort_next_ldvalue", ld_log[$], 2);
        check("abort_no_done_cnt", done_cnt, d0);
        run_until_done(20);
        idle(2);

        // Reset mid-RUN with two queued commands.
        step(1'b1, 4'd0, 4'd10, 1'b0, 1'b0);
        step(1'b1, 4'd3, 4'd4, 1'b0, 1'b0);
        step(1'b1, 4'd5, 4'd6, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 4'd7, 4'd7, 1'b0, 1'b1);
        step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        check("rst_mid_ready", cmd_ready, 0);
        check("rst_mid_ld", ld, 0);
        check("rst_mid_ldvalue", ldvalue, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        d0 = done_cnt;
        idle(25);
        check("rst_flushed_no_done", done_cnt, d0);
        step(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
        run_until_done(20);
        check("rst_after_ldvalue", ld_log[$], 1);
        check("rst_after_done_dist", done_cyc - fall_cyc, 2);

        // Randomised traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom),
                 $urandom_range(0, 24) == 0, $urandom_range(0, 149) == 0);
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
